sq_fold_add_pipe: RTL and testbench
===================================

Name: sq_fold_add_pipe

Overview:
- Parametrised, valid/ready pipelined datapath for two WIDTH-bit operand streams.
- Each operand is squared, and each square is folded to WIDTH bits by XORing its low half with its high half.
- The two folded values are summed, and the sum is delayed through a configurable number of output stages.
- Successor to the fixed 16-bit flopped adder benches. Adds width/depth generality, flow control with backpressure, and a full-width carry output. Used as a timing and area characterisation block.

Parameters:
- WIDTH, 16, operand width in bits; must be >= 2.
- OUT_STAGES, 1, number of register stages after the adder; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair a/b is valid this cycle.
- in_ready  output  1  pipeline accepts a/b this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  sum is valid.
- out_ready  input  1  downstream accepts sum this cycle.
- sum  output  WIDTH+1  folded-square sum; MSB is the carry.

Behaviour:
- Stages, all registered:
  - S1: a_q, b_q.
  - S2: sq_a = a_q*a_q and sq_b = b_q*b_q, each 2*WIDTH bits.
  - S3: f_a = sq_a[WIDTH-1:0] ^ sq_a[2*WIDTH-1:WIDTH]; f_b likewise for sq_b.
  - S4 .. S(3+OUT_STAGES): the first of these stages registers the zero-extended sum f_a + f_b (WIDTH+1 bits); the remaining stages shift it along.
- Output: sum and out_valid are the last stage's data and valid. No combinational path from a or b to sum.
- Each stage carries a valid bit alongside its data.
- Global advance: en = !out_valid || out_ready. When en=1, every stage loads from its predecessor, including its valid bit; S1 loads in_valid, a and b.
- in_ready = en, combinational from out_valid and out_ready only.
- Transfer rules:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- Stall (en=0): all stage data and valid bits hold. sum and out_valid must stay stable while out_valid=1 and out_ready=0.
- Bubbles: a valid=0 slot advances like data and is not compressed out. Stage data under valid=0 is don't-care, but is still loaded (no data gating required).
- Latency: L = 3 + OUT_STAGES cycles from input transfer to out_valid, with no stalls. Default L = 4. Throughput is 1 result per cycle while out_ready=1.
- Ordering: results emerge in acceptance order. Each stall cycle adds 1 cycle of delay to every in-flight item.
- Arithmetic:
  - Squares are unsigned and exact at 2*WIDTH bits.
  - The sum never truncates; the carry goes to sum[WIDTH].
- Reset: async assert clears all valid bits and all data registers to 0. Hence out_valid=0, sum=0, and in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight items; none appear after deassertion. Release is synchronous to clk via the standard reset synchroniser upstream.
- Simultaneous output transfer and input transfer in one cycle is legal and required for full throughput.

Optional Feature:
- Macro: SQ_FOLD_ADD_CARRY_CNT_EN.
- When defined:
  - Adds output port carry_cnt, 16 bits.
  - Counts output transfers with sum[WIDTH]=1.
  - Saturates at 0xFFFF; holds on stall; resets to 0.
- When undefined: the port and its logic are absent. The rest of the behaviour is identical.

Test Plan:
- WIDTH=16, OUT_STAGES=1, out_ready=1: a=3, b=5 with one in_valid pulse -> out_valid exactly 4 cycles later, sum=0x00022 (9+25).
- a=0xFFFF, b=0xFFFF -> each fold = 0x0001^0xFFFE = 0xFFFF; sum=0x1FFFE. With the macro defined, carry_cnt increments 0->1.
- Back-to-back stream a=i, b=0 for i=0..9 -> 10 consecutive out_valid cycles; sum[i]=i*i for i<=9, since all squares are below 2^16 and the high half is 0.
- Hold out_ready=0 for 5 cycles with 4 items in flight -> in_ready=0, sum and out_valid stable. Release -> all 4 results emerge in order, none lost or duplicated.
- Assert rst for 1 cycle with 3 items in flight -> out_valid=0 and sum=0 immediately (async). No stale results after release. in_ready=1 the next cycle.
- WIDTH=8, OUT_STAGES=3: a=0xFF, b=0x10 -> latency 6; fold_a = 0x01^0xFE = 0xFF, fold_b = 0x00^0x01 = 0x01; sum=0x100.

Source files
------------

// File: rtl/sq_fold_add_pipe.sv
// sq_fold_add_pipe
//
// Purpose:
//   Pipelined valid/ready datapath for two WIDTH-bit operand streams. Each
//   operand is squared exactly (2*WIDTH bits). Each square is folded to WIDTH
//   bits by XORing its low half with its high half. The two folded values are
//   added without truncation, and the sum is delayed through OUT_STAGES
//   registers. The whole pipeline advances together whenever the output slot
//   is empty or is being consumed. Latency is 3 + OUT_STAGES cycles.
//
// Parameters:
//   WIDTH      operand width in bits (>= 2)
//   OUT_STAGES number of register stages after the adder (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears all valid and data flops
//   in_valid   operand pair a/b valid this cycle
//   in_ready   pipeline accepts a/b this cycle (combinational from out_valid/out_ready)
//   a, b       WIDTH-bit operands
//   out_valid  sum is valid
//   out_ready  downstream accepts sum this cycle
//   sum        WIDTH+1-bit folded-square sum; the MSB is the carry
//   carry_cnt  (only with SQ_FOLD_ADD_CARRY_CNT_EN defined) saturating 16-bit
//              count of output transfers whose sum carry bit is set
//
// Optional feature macro: SQ_FOLD_ADD_CARRY_CNT_EN

module sq_fold_add_pipe #(
  parameter int WIDTH      = 16,
  parameter int OUT_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef SQ_FOLD_ADD_CARRY_CNT_EN
  ,
  output logic [15:0]      carry_cnt
`endif
);

  localparam int SQ_W = 2 * WIDTH;

  logic             en;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic             s2_valid_q, s2_valid_d;
  logic [SQ_W-1:0]  sq_a_q, sq_a_d;
  logic [SQ_W-1:0]  sq_b_q, sq_b_d;

  logic             s3_valid_q, s3_valid_d;
  logic [WIDTH-1:0] f_a_q, f_a_d;
  logic [WIDTH-1:0] f_b_q, f_b_d;

  logic             out_valid_q [OUT_STAGES];
  logic             out_valid_d [OUT_STAGES];
  logic [WIDTH:0]   out_data_q  [OUT_STAGES];
  logic [WIDTH:0]   out_data_d  [OUT_STAGES];

  assign out_valid = out_valid_q[OUT_STAGES-1];
  assign sum       = out_data_q[OUT_STAGES-1];

  // The pipeline moves as one unit: an empty or draining output slot lets
  // every stage shift forward. Bubbles travel like data and are never
  // squeezed out, so latency stays fixed at 3 + OUT_STAGES.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    s2_valid_d = s2_valid_q;
    sq_a_d     = sq_a_q;
    sq_b_d     = sq_b_q;
    s3_valid_d = s3_valid_q;
    f_a_d      = f_a_q;
    f_b_d      = f_b_q;
    for (int i = 0; i < OUT_STAGES; i++) begin
      out_valid_d[i] = out_valid_q[i];
      out_data_d[i]  = out_data_q[i];
    end

    if (en) begin
      s1_valid_d = in_valid;
      a_d        = a;
      b_d        = b;

      // Zero-extend before multiplying so the square is exact at 2*WIDTH bits.
      s2_valid_d = s1_valid_q;
      sq_a_d     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, a_q};
      sq_b_d     = {{WIDTH{1'b0}}, b_q} * {{WIDTH{1'b0}}, b_q};

      s3_valid_d = s2_valid_q;
      f_a_d      = sq_a_q[WIDTH-1:0] ^ sq_a_q[SQ_W-1:WIDTH];
      f_b_d      = sq_b_q[WIDTH-1:0] ^ sq_b_q[SQ_W-1:WIDTH];

      // One extra bit keeps the carry of the addition.
      out_valid_d[0] = s3_valid_q;
      out_data_d[0]  = {1'b0, f_a_q} + {1'b0, f_b_q};
      for (int i = 1; i < OUT_STAGES; i++) begin
        out_valid_d[i] = out_valid_q[i-1];
        out_data_d[i]  = out_data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      s2_valid_q <= 1'b0;
      sq_a_q     <= '0;
      sq_b_q     <= '0;
      s3_valid_q <= 1'b0;
      f_a_q      <= '0;
      f_b_q      <= '0;
      for (int i = 0; i < OUT_STAGES; i++) begin
        out_valid_q[i] <= 1'b0;
        out_data_q[i]  <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s2_valid_q <= s2_valid_d;
      sq_a_q     <= sq_a_d;
      sq_b_q     <= sq_b_d;
      s3_valid_q <= s3_valid_d;
      f_a_q      <= f_a_d;
      f_b_q      <= f_b_d;
      for (int i = 0; i < OUT_STAGES; i++) begin
        out_valid_q[i] <= out_valid_d[i];
        out_data_q[i]  <= out_data_d[i];
      end
    end
  end

`ifdef SQ_FOLD_ADD_CARRY_CNT_EN
  logic [15:0] carry_cnt_q, carry_cnt_d;

  assign carry_cnt = carry_cnt_q;

  // Counts only real output transfers with the carry set. A stalled result
  // is not counted until it actually leaves, and the count sticks at all-ones.
  always_comb begin
    carry_cnt_d = carry_cnt_q;
    if (out_valid && out_ready && sum[WIDTH] && (carry_cnt_q != 16'hFFFF)) begin
      carry_cnt_d = carry_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_cnt_q <= '0;
    end else begin
      carry_cnt_q <= carry_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_sq_fold_add_pipe.sv
// Testbench for sq_fold_add_pipe (WIDTH=16, OUT_STAGES=1).
// Stimulus pushes expected sums into a scoreboard queue. An independent
// monitor pops and compares on every output transfer, and it also checks
// that a stalled output holds steady.

module tb_sq_fold_add_pipe;

  localparam int W   = 16;
  localparam int OST = 1;
  localparam int LAT = 3 + OST;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;
`ifdef SQ_FOLD_ADD_CARRY_CNT_EN
  logic [15:0]  carry_cnt;
  int unsigned  cntModel;
`endif

  int           compared   = 0;
  int           mismatched = 0;
  logic [W:0]   sb[$];
  logic         prevStall;
  logic [W:0]   prevSum;
  int           run;
  int           maxRun;
  bit           randActive;

  sq_fold_add_pipe #(.WIDTH(W), .OUT_STAGES(OST)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
`ifdef SQ_FOLD_ADD_CARRY_CNT_EN
    ,
    .carry_cnt (carry_cnt)
`endif
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reference model: exact square, fold the halves with plain arithmetic,
  // then add the two folded values without truncation.
  function automatic logic [W:0] refModel(input longint unsigned x, input longint unsigned y);
    longint unsigned base;
    longint unsigned sx;
    longint unsigned sy;
    longint unsigned fx;
    longint unsigned fy;
    base = longint'(1) << W;
    sx   = x * x;
    sy   = y * y;
    fx   = (sx % base) ^ (sx / base);
    fy   = (sy % base) ^ (sy / base);
    return (W+1)'(fx + fy);
  endfunction

  task automatic checkOutput(input string name, input longint unsigned actual,
                             input longint unsigned expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one operand pair and holds it until the pipeline accepts it.
  // Returns #1 after the accepting edge with in_valid still high.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(refModel(av, bv));
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && sb.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_empty", sb.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks that a
  // stalled output keeps its data and valid until it is consumed.
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
      run       = 0;
`ifdef SQ_FOLD_ADD_CARRY_CNT_EN
      cntModel  = 0;
`endif
    end else begin
`ifdef SQ_FOLD_ADD_CARRY_CNT_EN
      checkOutput("carry_cnt", carry_cnt, cntModel);
`endif
      if (prevStall) begin
        checkOutput("stall_valid_hold", out_valid, 1);
        checkOutput("stall_sum_hold", sum, prevSum);
      end
      if (out_valid && !out_ready) begin
        checkOutput("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_output: got sum=0x%0h expected no output", sum);
        end else begin
          logic [W:0] exp;
          exp = sb.pop_front();
          checkOutput("sum", sum, exp);
`ifdef SQ_FOLD_ADD_CARRY_CNT_EN
          if (exp[W] && cntModel < 65535) cntModel++;
`endif
        end
      end
      run = out_valid ? run + 1 : 0;
      if (run > maxRun) maxRun = run;
      prevStall = out_valid && !out_ready;
      prevSum   = sum;
    end
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    out_ready  = 1'b1;
    maxRun     = 0;
    randActive = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single item 3,5: latency and value 9+25.
    applyStimulus(16'd3, 16'd5);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("latency", n, LAT);
    idleCycles(3);

    // All-ones operands exercise the carry.
    applyStimulus(16'hFFFF, 16'hFFFF);
    idleCycles(6);
    drain();

    // Back-to-back stream a=i, b=0: ten consecutive results.
    maxRun = 0;
    for (int i = 0; i < 10; i++) applyStimulus(W'(i), '0);
    idleCycles(8);
    drain();
    checkOutput("stream_run_length", maxRun, 10);

    // Backpressure: four items in flight, output held for five cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(W'($urandom), W'($urandom));
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checkOutput("backpressure_in_ready", in_ready, 0);
    checkOutput("backpressure_out_valid", out_valid, 1);
    checkOutput("backpressure_queued", sb.size(), 4);
    out_ready = 1'b1;
    drain();

    // Random traffic with random backpressure.
    randActive = 1'b1;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          idleCycles($urandom_range(0, 2));
          applyStimulus(W'($urandom), W'($urandom));
        end
        in_valid   = 1'b0;
        randActive = 1'b0;
      end
      begin
        while (randActive) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with three items in flight and the head stalled at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(W'($urandom_range(1, 65535)), 16'hFFFF);
    in_valid = 1'b0;
    for (int t = 0; t < 20 && !out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre_reset_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_out_valid", out_valid, 0);
    checkOutput("async_reset_sum", sum, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_in_ready", in_ready, 1);
    idleCycles(10);
    checkOutput("post_reset_no_output", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
